// File: rtl/tetris_cmd_scheduler_if.sv
// Command bus between the scheduler and block_control: one-hot move command
// with a valid/ready handshake, plus a completion pulse from the consumer.
interface tetris_cmd_scheduler_if;
    logic       ctrl_valid;
    logic [7:0] ctrl_cmd;
    logic       ctrl_ready;
    logic       cmd_done;

    modport master (output ctrl_valid, ctrl_cmd, input ctrl_ready, cmd_done);
    modport slave  (input ctrl_valid, ctrl_cmd, output ctrl_ready, cmd_done);
endinterface

// File: rtl/tetris_cmd_scheduler.sv
// Move-command scheduler: collects button and gravity requests into a
// pending set, issues them one at a time to block_control, and waits for
// completion (or a timeout) before issuing the next.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | game not running; pending cleared, gravity counter held loaded
// S_ARB   | pick highest-priority pending request (DOWN>HOLD>ROT>LEFT>RIGHT)
// S_ISSUE | ctrl_valid high, waiting for ctrl_ready
// S_WAIT  | command accepted, waiting for cmd_done or timeout
module tetris_cmd_scheduler #(
    parameter int CNT_W          = 25,
    parameter int GRAVITY_PERIOD = 25_000_000,
    parameter int MIN_PERIOD     = 2_500_000,
    parameter int SPEEDUP_STEP   = 1_250_000,
    parameter int CMD_TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   over,
    input  logic [3:0]             btn_pressed,
    input  logic                   soft_drop,
    input  logic                   level_up,
    tetris_cmd_scheduler_if.master ctrl,
    output logic                   busy,
    output logic [4:0]             drop_cnt,
    output logic                   timeout_err,
    output logic [CNT_W-1:0]       gravity_period
);
    localparam int WT_W = $clog2(CMD_TIMEOUT);
    localparam logic [WT_W-1:0]  WT_LOAD  = WT_W'(CMD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GP_INIT  = CNT_W'(GRAVITY_PERIOD);
    localparam logic [CNT_W-1:0] GP_MIN   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] GP_STEP  = CNT_W'(SPEEDUP_STEP);
    localparam logic [CNT_W:0]   GP_FLOOR = (CNT_W+1)'(MIN_PERIOD + SPEEDUP_STEP);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_WAIT} state_t;

    state_t           state;
    logic [4:0]       pending;
    logic [4:0]       req;
    logic [4:0]       sel;
    logic [4:0]       grant;
    logic [4:0]       coalesce;
    logic [5:0]       drop_sum;
    logic [4:0]       drop_next;
    logic             force_idle;
    logic             gravity_fire;
    logic [CNT_W-1:0] grav_cnt;
    logic [CNT_W-1:0] gp_div;
    logic [CNT_W-1:0] eff;
    logic [CNT_W-1:0] gp_step;
    logic [WT_W-1:0]  wait_cnt;

    assign force_idle   = over || !enable;
    assign gravity_fire = (state != S_IDLE) && (grav_cnt <= CNT_W'(1));
    assign req          = {gravity_fire, btn_pressed};
    assign grant        = (state == S_ARB) ? sel : 5'b0;
    assign coalesce     = req & pending;

    // Fixed-priority pick, request helpers and gravity arithmetic.
    always_comb begin
        sel = 5'b0;
        if (pending[4])      sel = 5'b10000;
        else if (pending[3]) sel = 5'b01000;
        else if (pending[2]) sel = 5'b00100;
        else if (pending[0]) sel = 5'b00001;
        else if (pending[1]) sel = 5'b00010;

        drop_sum  = {1'b0, drop_cnt} + 6'($countones(coalesce));
        drop_next = (drop_sum > 6'd31) ? 5'd31 : drop_sum[4:0];

        gp_div  = gravity_period >> 3;
        eff     = soft_drop ? ((gp_div == '0) ? CNT_W'(1) : gp_div) : gravity_period;
        gp_step = ({1'b0, gravity_period} >= GP_FLOOR) ? (gravity_period - GP_STEP) : GP_MIN;
    end

    // Pending request set and saturating coalesce counter; a new request beats a grant-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 5'b0;
            drop_cnt <= 5'd0;
        end else if (force_idle) begin
            pending  <= 5'b0;
        end else begin
            pending  <= (pending & ~grant) | req;
            drop_cnt <= drop_next;
        end
    end

    // Gravity down-counter and base period with level-up speedup.
    always_ff @(posedge clk) begin
        if (reset) begin
            grav_cnt       <= GP_INIT;
            gravity_period <= GP_INIT;
        end else begin
            if (state == S_IDLE || gravity_fire)
                grav_cnt <= eff;
            else
                grav_cnt <= grav_cnt - CNT_W'(1);

            if (state == S_IDLE && !enable)
                gravity_period <= GP_INIT;
            else if (level_up)
                gravity_period <= gp_step;
        end
    end

    // Command FSM with registered bus outputs; stop/over abandons anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ctrl.ctrl_valid <= 1'b0;
            ctrl.ctrl_cmd   <= 8'h00;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            wait_cnt        <= '0;
        end else if (force_idle) begin
            state           <= S_IDLE;
            ctrl.ctrl_valid <= 1'b0;
            ctrl.ctrl_cmd   <= 8'h00;
            busy            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_ARB;
                S_ARB: begin
                    if (|pending) begin
                        state           <= S_ISSUE;
                        ctrl.ctrl_valid <= 1'b1;
                        ctrl.ctrl_cmd   <= {3'b000, sel};
                        busy            <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (ctrl.ctrl_ready) begin
                        state           <= S_WAIT;
                        ctrl.ctrl_valid <= 1'b0;
                        ctrl.ctrl_cmd   <= 8'h00;
                        wait_cnt        <= WT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (ctrl.cmd_done) begin
                        state <= S_ARB;
                        busy  <= 1'b0;
                    end else if (wait_cnt == '0) begin
                        state       <= S_ARB;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Bench for tetris_cmd_scheduler: directed scenarios on a full-size instance,
// gravity timing on a short-period instance, then randomized traffic against
// a transaction-level reference model.
module tb_tetris_cmd_scheduler;
    localparam longint GP_INIT = 25_000_000;
    localparam longint MINP    = 2_500_000;
    localparam longint STEP    = 1_250_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // full-size instance
    logic        reset_a, enable_a, over_a, soft_a, lvl_a;
    logic [3:0]  btn_a;
    logic        busy_a, to_a;
    logic [4:0]  drop_a;
    logic [24:0] gp_a;
    tetris_cmd_scheduler_if a_if ();

    tetris_cmd_scheduler dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .over(over_a),
        .btn_pressed(btn_a), .soft_drop(soft_a), .level_up(lvl_a),
        .ctrl(a_if.master), .busy(busy_a), .drop_cnt(drop_a),
        .timeout_err(to_a), .gravity_period(gp_a));

    // short gravity period instance
    logic        reset_b, enable_b, over_b, soft_b, lvl_b;
    logic [3:0]  btn_b;
    logic        busy_b, to_b;
    logic [4:0]  drop_b;
    logic [24:0] gp_b;
    tetris_cmd_scheduler_if b_if ();

    tetris_cmd_scheduler #(.GRAVITY_PERIOD(16), .MIN_PERIOD(2), .SPEEDUP_STEP(1)) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .over(over_b),
        .btn_pressed(btn_b), .soft_drop(soft_b), .level_up(lvl_b),
        .ctrl(b_if.master), .busy(busy_b), .drop_cnt(drop_b),
        .timeout_err(to_b), .gravity_period(gp_b));

    // reference model state
    int         m_st;     // 0 idle, 1 arbitrate, 2 offered, 3 awaiting done
    bit [4:0]   m_pend;
    logic       m_valid, m_busy, m_to;
    logic [7:0] m_cmd;
    int         m_drop, m_wait;
    longint     m_gp;
    int         prio [5] = '{4, 3, 2, 0, 1};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait for an offered command, accept it, then pulse done once
    task automatic serve(input string tag, output logic [7:0] cmd);
        int n = 0;
        while (!a_if.ctrl_valid && n < 40) begin step(); n++; end
        check({tag, "_seen"}, {31'd0, a_if.ctrl_valid}, 32'd1);
        cmd = a_if.ctrl_cmd;
        a_if.ctrl_ready = 1'b1;
        step();
        a_if.cmd_done = 1'b1;
        step();
        a_if.cmd_done = 1'b0;
    endtask

    task automatic model_reset();
        m_st = 0; m_pend = '0; m_valid = 0; m_busy = 0; m_to = 0;
        m_cmd = 8'h00; m_drop = 0; m_wait = 0; m_gp = GP_INIT;
    endtask

    // one clock of the game-level rules, applied to the inputs seen at that edge
    task automatic model_step(input logic en, input logic ov, input logic [3:0] btn,
                              input logic rdy, input logic dn, input logic lvl);
        bit stop;
        int g;
        stop = ov || !en;
        if (m_st == 0 && !en) m_gp = GP_INIT;
        else if (lvl) m_gp = (m_gp - STEP < MINP) ? MINP : m_gp - STEP;
        g = -1;
        if (m_st == 1)
            for (int i = 0; i < 5; i++)
                if (g < 0 && m_pend[prio[i]]) g = prio[i];
        if (stop) m_pend = '0;
        else begin
            for (int b = 0; b < 4; b++)
                if (btn[b] && m_pend[b] && m_drop < 31) m_drop++;
            if (g >= 0) m_pend[g] = 1'b0;
            m_pend[3:0] = m_pend[3:0] | btn;
        end
        if (stop) begin
            m_st = 0; m_valid = 0; m_cmd = 8'h00; m_busy = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (g >= 0) begin
                    m_st = 2; m_valid = 1; m_cmd = 8'(1 << g); m_busy = 1;
                end
                2: if (rdy) begin
                    m_st = 3; m_valid = 0; m_cmd = 8'h00; m_wait = 0;
                end
                default: begin
                    if (dn) begin
                        m_st = 1; m_busy = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == 1024) begin m_st = 1; m_busy = 0; m_to = 1; end
                    end
                end
            endcase
        end
    endtask

    initial begin
        logic [7:0] c;
        int     rises [3];
        int     nrise, cyc;
        logic   prev;
        int     n, d0, d1;
        longint exp_gp;

        reset_a = 1; enable_a = 0; over_a = 0; soft_a = 0; lvl_a = 0; btn_a = 0;
        a_if.ctrl_ready = 0; a_if.cmd_done = 0;
        reset_b = 1; enable_b = 0; over_b = 0; soft_b = 0; lvl_b = 0; btn_b = 0;
        b_if.ctrl_ready = 1; b_if.cmd_done = 1;
        step(); step();

        check("rst_valid", {31'd0, a_if.ctrl_valid}, 32'd0);
        check("rst_cmd",   {24'd0, a_if.ctrl_cmd}, 32'd0);
        check("rst_busy",  {31'd0, busy_a}, 32'd0);
        check("rst_drop",  {27'd0, drop_a}, 32'd0);
        check("rst_to",    {31'd0, to_a}, 32'd0);
        check("rst_gp",    {7'd0, gp_a}, 32'(GP_INIT));
        reset_a = 0; reset_b = 0;

        // gravity on the short instance: DOWN every 16 cycles
        enable_b = 1;
        nrise = 0; prev = 0;
        for (cyc = 0; cyc < 80 && nrise < 3; cyc++) begin
            step();
            if (b_if.ctrl_valid && !prev) begin
                rises[nrise] = cyc;
                nrise++;
                check("grav_cmd", {24'd0, b_if.ctrl_cmd}, 32'h10);
            end
            prev = b_if.ctrl_valid;
        end
        check("grav_rises", nrise, 3);
        if (nrise == 3) begin
            check("grav_int1", rises[1] - rises[0], 16);
            check("grav_int2", rises[2] - rises[1], 16);
        end
        // soft drop: stall the bus so every expiry past the first coalesces
        soft_b = 1; b_if.ctrl_ready = 0;
        repeat (40) step();
        d0 = int'(drop_b);
        repeat (20) step();
        d1 = int'(drop_b);
        check("soft_rate", d1 - d0, 10);

        // single ROTATE with 2-cycle latency
        enable_a = 1;
        step();
        btn_a = 4'b0100; step(); btn_a = 0;
        check("t1_lat_early", {31'd0, a_if.ctrl_valid}, 32'd0);
        step();
        check("t1_valid", {31'd0, a_if.ctrl_valid}, 32'd1);
        check("t1_cmd",   {24'd0, a_if.ctrl_cmd}, 32'h04);
        check("t1_busy",  {31'd0, busy_a}, 32'd1);
        a_if.ctrl_ready = 1; step();
        check("t1_drop_valid", {31'd0, a_if.ctrl_valid}, 32'd0);
        check("t1_zero_cmd",   {24'd0, a_if.ctrl_cmd}, 32'd0);
        check("t1_busy_wait",  {31'd0, busy_a}, 32'd1);
        step();
        a_if.cmd_done = 1; step(); a_if.cmd_done = 0;
        check("t1_idle_busy", {31'd0, busy_a}, 32'd0);

        // simultaneous LEFT/RIGHT/HOLD in priority order
        btn_a = 4'b1011; step(); btn_a = 0;
        serve("t2_a", c); check("t2_first",  {24'd0, c}, 32'h08);
        serve("t2_b", c); check("t2_second", {24'd0, c}, 32'h01);
        serve("t2_c", c); check("t2_third",  {24'd0, c}, 32'h02);

        // coalescing while stalled
        a_if.ctrl_ready = 0;
        btn_a = 4'b1000; step(); btn_a = 0; step();
        check("t5_stall_cmd", {24'd0, a_if.ctrl_cmd}, 32'h08);
        repeat (3) begin btn_a = 4'b0001; step(); btn_a = 0; step(); end
        check("t5_drop2", {27'd0, drop_a}, 32'd2);
        serve("t5_hold", c); check("t5_hold_cmd", {24'd0, c}, 32'h08);
        serve("t5_left", c); check("t5_left_cmd", {24'd0, c}, 32'h01);
        repeat (5) step();
        check("t5_single", {31'd0, a_if.ctrl_valid}, 32'd0);
        a_if.ctrl_ready = 0;
        btn_a = 4'b1000; step(); btn_a = 0; step();
        repeat (40) begin btn_a = 4'b0001; step(); btn_a = 0; step(); end
        check("t5_sat", {27'd0, drop_a}, 32'd31);
        over_a = 1; step(); over_a = 0; step();
        check("t5_flush", {31'd0, a_if.ctrl_valid}, 32'd0);

        // command timeout, then abort during ISSUE
        btn_a = 4'b0100; step(); btn_a = 0; step();
        check("t6_cmd", {24'd0, a_if.ctrl_cmd}, 32'h04);
        a_if.ctrl_ready = 1; step(); a_if.ctrl_ready = 0;
        n = 0;
        while (!to_a && n < 1100) begin step(); n++; end
        check("t6_to_cycles", n, 1024);
        check("t6_to_flag",   {31'd0, to_a}, 32'd1);
        check("t6_to_busy",   {31'd0, busy_a}, 32'd0);
        btn_a = 4'b0010; step(); btn_a = 0; step();
        check("t6_issue", {24'd0, a_if.ctrl_cmd}, 32'h02);
        over_a = 1; step();
        check("t6_ov_valid", {31'd0, a_if.ctrl_valid}, 32'd0);
        check("t6_ov_cmd",   {24'd0, a_if.ctrl_cmd}, 32'd0);
        check("t6_ov_busy",  {31'd0, busy_a}, 32'd0);
        check("t6_sticky",   {31'd0, to_a}, 32'd1);
        over_a = 0; step();

        // level_up clamp and restore on stop
        for (int k = 1; k <= 20; k++) begin
            lvl_a = 1; step();
            exp_gp = GP_INIT - longint'(k) * STEP;
            if (exp_gp < MINP) exp_gp = MINP;
            check($sformatf("t4_gp%0d", k), {7'd0, gp_a}, 32'(exp_gp));
        end
        lvl_a = 0;
        enable_a = 0; step(); step();
        check("t4_restore", {7'd0, gp_a}, 32'(GP_INIT));

        // randomized traffic against the reference model
        reset_a = 1; step(); step(); reset_a = 0;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            check("r_valid", {31'd0, a_if.ctrl_valid}, {31'd0, m_valid});
            check("r_cmd",   {24'd0, a_if.ctrl_cmd}, {24'd0, m_cmd});
            check("r_busy",  {31'd0, busy_a}, {31'd0, m_busy});
            check("r_drop",  {27'd0, drop_a}, 32'(m_drop));
            check("r_to",    {31'd0, to_a}, {31'd0, m_to});
            check("r_gp",    {7'd0, gp_a}, 32'(m_gp));
            enable_a = ($urandom_range(0, 63) != 0);
            over_a   = ($urandom_range(0, 63) == 0);
            btn_a    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                        ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            soft_a   = 1'($urandom_range(0, 1));
            lvl_a    = ($urandom_range(0, 15) == 0);
            a_if.ctrl_ready = ($urandom_range(0, 2) != 0);
            a_if.cmd_done   = ($urandom_range(0, 3) == 0);
            model_step(enable_a, over_a, btn_a, a_if.ctrl_ready, a_if.cmd_done, lvl_a);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
